// File: rtl/minisrc_ctrl_pkg.sv
// minisrc_ctrl_pkg
//   Shared constants for the MiniSRC hardwired control sequencer:
//   instruction field positions, opcodes, ALU operation codes, sequencer
//   state encoding and the decoded-opcode record produced by
//   minisrc_op_decode.
//   Optional feature macro: MINISRC_MULDIV_EN (MUL/DIV support).
package minisrc_ctrl_pkg;

    // Instruction register field positions
    localparam int OP_HI = 31;
    localparam int OP_LO = 27;
    localparam int RA_HI = 26;
    localparam int RA_LO = 23;
    localparam int RB_HI = 22;
    localparam int RB_LO = 19;
    localparam int RC_HI = 18;
    localparam int RC_LO = 15;

    // Opcodes (IR[31:27])
    localparam logic [4:0] OPC_ADD  = 5'd3;
    localparam logic [4:0] OPC_SUB  = 5'd4;
    localparam logic [4:0] OPC_AND  = 5'd5;
    localparam logic [4:0] OPC_OR   = 5'd6;
    localparam logic [4:0] OPC_SHR  = 5'd7;
    localparam logic [4:0] OPC_SHRA = 5'd8;
    localparam logic [4:0] OPC_SHL  = 5'd9;
    localparam logic [4:0] OPC_ROR  = 5'd10;
    localparam logic [4:0] OPC_ROL  = 5'd11;
    localparam logic [4:0] OPC_MUL  = 5'd15;
    localparam logic [4:0] OPC_DIV  = 5'd16;
    localparam logic [4:0] OPC_NEG  = 5'd17;
    localparam logic [4:0] OPC_NOT  = 5'd18;

    // ALU operation select codes
    localparam logic [3:0] ALU_AND  = 4'h0;
    localparam logic [3:0] ALU_OR   = 4'h1;
    localparam logic [3:0] ALU_ADD  = 4'h2;
    localparam logic [3:0] ALU_SUB  = 4'h3;
    localparam logic [3:0] ALU_MUL  = 4'h4;
    localparam logic [3:0] ALU_DIV  = 4'h6;
    localparam logic [3:0] ALU_SHR  = 4'h7;
    localparam logic [3:0] ALU_SHRA = 4'h8;
    localparam logic [3:0] ALU_SHL  = 4'h9;
    localparam logic [3:0] ALU_ROR  = 4'hA;
    localparam logic [3:0] ALU_ROL  = 4'hB;
    localparam logic [3:0] ALU_NEG  = 4'hC;
    localparam logic [3:0] ALU_NOT  = 4'hD;

    // Sequencer state encoding
    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_GAP  = 4'd1;
    localparam logic [3:0] ST_T0   = 4'd2;
    localparam logic [3:0] ST_T1   = 4'd3;
    localparam logic [3:0] ST_T2   = 4'd4;
    localparam logic [3:0] ST_T3   = 4'd5;
    localparam logic [3:0] ST_T4   = 4'd6;
    localparam logic [3:0] ST_T5   = 4'd7;
    localparam logic [3:0] ST_T6   = 4'd8;
    localparam logic [3:0] ST_ERR  = 4'd9;

    // Decoded opcode classification
    typedef struct packed {
        logic [3:0] alu_op;
        logic       is_two_op;
        logic       is_unary;
        logic       is_muldiv;
        logic       illegal;
    } op_dec_t;

endpackage

// File: rtl/minisrc_alu_ctrl_seq_chk.sv
// minisrc_alu_ctrl_seq_chk
//   Property checker for the control sequencer: the shared bus never has
//   more than one driver enabled in a cycle.
//   Ports:
//     clk      in  1  sequencer clock
//     rst      in  1  synchronous active-high reset (check disabled)
//     bus_out  in  5  {PCout, Zlowout, Zhighout, MDRout, Rout}
module minisrc_alu_ctrl_seq_chk (
    input logic       clk,
    input logic       rst,
    input logic [4:0] bus_out
);

    a_bus_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(bus_out));

endmodule

// File: rtl/minisrc_op_decode.sv
// minisrc_op_decode
//   Combinational opcode classifier: maps the 5-bit opcode to the ALU
//   operation code and the instruction class (two-operand, unary,
//   multiply/divide, unsupported). Also used by the branch/memory sequencer.
//   Ports:
//     opcode  in   5  IR[31:27]
//     dec     out     decoded record (op_dec_t)
//   Optional feature macro: MINISRC_MULDIV_EN makes MUL and DIV legal.
module minisrc_op_decode
    import minisrc_ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    output op_dec_t    dec
);

    // Opcode lookup; anything not listed is reported as illegal
    always_comb begin
        dec.alu_op    = ALU_AND;
        dec.is_two_op = 1'b0;
        dec.is_unary  = 1'b0;
        dec.is_muldiv = 1'b0;
        dec.illegal   = 1'b0;
        case (opcode)
            OPC_ADD:  begin dec.alu_op = ALU_ADD;  dec.is_two_op = 1'b1; end
            OPC_SUB:  begin dec.alu_op = ALU_SUB;  dec.is_two_op = 1'b1; end
            OPC_AND:  begin dec.alu_op = ALU_AND;  dec.is_two_op = 1'b1; end
            OPC_OR:   begin dec.alu_op = ALU_OR;   dec.is_two_op = 1'b1; end
            OPC_SHR:  begin dec.alu_op = ALU_SHR;  dec.is_two_op = 1'b1; end
            OPC_SHRA: begin dec.alu_op = ALU_SHRA; dec.is_two_op = 1'b1; end
            OPC_SHL:  begin dec.alu_op = ALU_SHL;  dec.is_two_op = 1'b1; end
            OPC_ROR:  begin dec.alu_op = ALU_ROR;  dec.is_two_op = 1'b1; end
            OPC_ROL:  begin dec.alu_op = ALU_ROL;  dec.is_two_op = 1'b1; end
            OPC_NEG:  begin dec.alu_op = ALU_NEG;  dec.is_unary  = 1'b1; end
            OPC_NOT:  begin dec.alu_op = ALU_NOT;  dec.is_unary  = 1'b1; end
`ifdef MINISRC_MULDIV_EN
            OPC_MUL:  begin dec.alu_op = ALU_MUL;  dec.is_muldiv = 1'b1; end
            OPC_DIV:  begin dec.alu_op = ALU_DIV;  dec.is_muldiv = 1'b1; end
`endif
            default:  begin dec.illegal = 1'b1; end
        endcase
    end

endmodule

// File: rtl/minisrc_alu_ctrl_seq.sv
// minisrc_alu_ctrl_seq
//   Hardwired control sequencer for the MiniSRC datapath: fetch (T0-T2)
//   followed by register-to-register ALU execution (T3-T5, T6 for MUL/DIV).
//   Strobes are decoded combinationally from the state register; T3..T6
//   strobes also depend on the opcode in IR.
//   Ports:
//     Clock, Reset            clock and synchronous active-high reset
//     Run                     level; keep sequencing instructions while high
//     IR                      instruction register contents from DataPath
//     PCout..Rout             bus drive strobes
//     MARin..HIin             register load strobes
//     IncPC, Read             PC increment and memory read
//     Gra, Grb, Grc           register-field select
//     AluOp                   ALU operation select (0 outside T3/T4)
//     InstrDone               pulse in the last step of each instruction
//     Illegal                 high while parked in ERR (cleared only by Reset)
//     RetiredCnt              completed-instruction count, wraps at 16 bits
//   Parameter RUN_IDLE_CYCLES (0..3): idle cycles between instructions.
//   Optional feature macro: MINISRC_MULDIV_EN adds MUL/DIV (T6, LO/HI load).
module minisrc_alu_ctrl_seq
    import minisrc_ctrl_pkg::*;
#(
    parameter int unsigned RUN_IDLE_CYCLES = 32'd0
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Run,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        MDRout,
    output logic        Rout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Rin,
    output logic        LOin,
    output logic        HIin,
    output logic        IncPC,
    output logic        Read,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic [3:0]  AluOp,
    output logic        InstrDone,
    output logic        Illegal,
    output logic [15:0] RetiredCnt
);

    // GAP counts down from RUN_IDLE_CYCLES-1 to 0, then moves to T0
    localparam logic [1:0] GAP_LOAD = (RUN_IDLE_CYCLES > 32'd0) ?
                                      2'(RUN_IDLE_CYCLES - 32'd1) : 2'd0;

    logic [3:0]  state_r;
    logic [3:0]  state_nxt_s;
    logic [3:0]  end_nxt_s;
    logic [1:0]  gap_cnt_r;
    logic [15:0] retired_r;
    logic        last_step_s;
    logic        zhighout_s;
    logic        lo_in_s;
    logic        hi_in_s;
    op_dec_t     dec_s;

    // Register fields are consumed by the select/encode logic, not here;
    // the summary illegal flag is for other consumers since this sequencer
    // branches on the positive op classes.
    logic unused_ir_s;
    logic unused_dec_s;
    assign unused_ir_s = ^IR[RA_HI:0];
`ifdef MINISRC_MULDIV_EN
    assign unused_dec_s = dec_s.illegal;
`else
    assign unused_dec_s = dec_s.illegal ^ dec_s.is_muldiv;
`endif

    minisrc_op_decode u_op_decode (
        .opcode (IR[OP_HI:OP_LO]),
        .dec    (dec_s)
    );

    // Where to go after the final step of an instruction
    assign end_nxt_s = (Run == 1'b0) ? ST_IDLE :
                       ((RUN_IDLE_CYCLES == 32'd0) ? ST_T0 : ST_GAP);

    // Next-state and strobe decode from the state register (and IR in T3+)
    always_comb begin
        state_nxt_s = state_r;
        last_step_s = 1'b0;
        PCout = 1'b0;  Zlowout = 1'b0;  MDRout = 1'b0;  Rout = 1'b0;
        MARin = 1'b0;  PCin    = 1'b0;  MDRin  = 1'b0;  IRin = 1'b0;
        Yin   = 1'b0;  Zin     = 1'b0;  Rin    = 1'b0;
        IncPC = 1'b0;  Read    = 1'b0;
        Gra   = 1'b0;  Grb     = 1'b0;  Grc    = 1'b0;
        AluOp = ALU_AND;
        InstrDone  = 1'b0;
        Illegal    = 1'b0;
        zhighout_s = 1'b0;
        lo_in_s    = 1'b0;
        hi_in_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (Run) state_nxt_s = ST_T0;
                else     state_nxt_s = ST_IDLE;
            end
            ST_GAP: begin
                if (gap_cnt_r == 2'd0) state_nxt_s = ST_T0;
                else                   state_nxt_s = ST_GAP;
            end
            ST_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                state_nxt_s = ST_T1;
            end
            ST_T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                state_nxt_s = ST_T2;
            end
            ST_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                state_nxt_s = ST_T3;
            end
            ST_T3: begin
                if (dec_s.is_two_op) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    state_nxt_s = ST_T4;
                end else if (dec_s.is_unary) begin
                    // single-operand ops issue to the ALU right away and skip T4
                    Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; AluOp = dec_s.alu_op;
                    state_nxt_s = ST_T5;
`ifdef MINISRC_MULDIV_EN
                end else if (dec_s.is_muldiv) begin
                    Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    state_nxt_s = ST_T4;
`endif
                end else begin
                    state_nxt_s = ST_ERR;
                end
            end
            ST_T4: begin
                Rout = 1'b1; Zin = 1'b1; AluOp = dec_s.alu_op;
`ifdef MINISRC_MULDIV_EN
                if (dec_s.is_muldiv) Grb = 1'b1;
                else                 Grc = 1'b1;
`else
                Grc = 1'b1;
`endif
                state_nxt_s = ST_T5;
            end
            ST_T5: begin
                Zlowout = 1'b1;
`ifdef MINISRC_MULDIV_EN
                if (dec_s.is_muldiv) begin
                    lo_in_s = 1'b1;
                    state_nxt_s = ST_T6;
                end else begin
                    Gra = 1'b1; Rin = 1'b1; InstrDone = 1'b1;
                    last_step_s = 1'b1;
                    state_nxt_s = end_nxt_s;
                end
`else
                Gra = 1'b1; Rin = 1'b1; InstrDone = 1'b1;
                last_step_s = 1'b1;
                state_nxt_s = end_nxt_s;
`endif
            end
`ifdef MINISRC_MULDIV_EN
            ST_T6: begin
                zhighout_s = 1'b1; hi_in_s = 1'b1; InstrDone = 1'b1;
                last_step_s = 1'b1;
                state_nxt_s = end_nxt_s;
            end
`endif
            ST_ERR: begin
                Illegal = 1'b1;
                state_nxt_s = ST_ERR;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign Zhighout   = zhighout_s;
    assign LOin       = lo_in_s;
    assign HIin       = hi_in_s;
    assign RetiredCnt = retired_r;

    // State, inter-instruction gap counter and retired-instruction counter
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r   <= ST_IDLE;
            gap_cnt_r <= 2'd0;
            retired_r <= 16'd0;
        end else begin
            state_r <= state_nxt_s;
            if (last_step_s) begin
                retired_r <= retired_r + 16'd1;
                gap_cnt_r <= GAP_LOAD;
            end else if ((state_r == ST_GAP) && (gap_cnt_r != 2'd0)) begin
                retired_r <= retired_r;
                gap_cnt_r <= gap_cnt_r - 2'd1;
            end else begin
                retired_r <= retired_r;
                gap_cnt_r <= gap_cnt_r;
            end
        end
    end

    minisrc_alu_ctrl_seq_chk u_chk (
        .clk     (Clock),
        .rst     (Reset),
        .bus_out ({PCout, Zlowout, Zhighout, MDRout, Rout})
    );

endmodule

// File: tb/tb_minisrc_alu_ctrl_seq.sv
// tb_minisrc_alu_ctrl_seq
//   Scoreboard bench: each issued instruction pushes its expected per-cycle
//   strobe vectors; every negative clock edge pops one and compares it with
//   the DUT outputs, along with the retired-instruction count. The bench
//   plays DataPath by loading IR whenever IRin is seen.
module tb_minisrc_alu_ctrl_seq;

    localparam int unsigned GAPS = 32'd0;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Run;
    logic [31:0] IR;
    logic        PCout, Zlowout, Zhighout, MDRout, Rout;
    logic        MARin, PCin, MDRin, IRin, Yin, Zin, Rin, LOin, HIin;
    logic        IncPC, Read, Gra, Grb, Grc, InstrDone, Illegal;
    logic [3:0]  AluOp;
    logic [15:0] RetiredCnt;

    minisrc_alu_ctrl_seq #(.RUN_IDLE_CYCLES(GAPS)) dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .IR(IR),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout), .Rout(Rout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Rin(Rin), .LOin(LOin), .HIin(HIin), .IncPC(IncPC), .Read(Read),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .AluOp(AluOp), .InstrDone(InstrDone),
        .Illegal(Illegal), .RetiredCnt(RetiredCnt)
    );

    always #5 Clock = ~Clock;

    // Bit positions in the packed strobe vector
    localparam logic [24:0] M_PCOUT   = 25'h1 << 24;
    localparam logic [24:0] M_ZLOWOUT = 25'h1 << 23;
    localparam logic [24:0] M_ZHIOUT  = 25'h1 << 22;
    localparam logic [24:0] M_MDROUT  = 25'h1 << 21;
    localparam logic [24:0] M_ROUT    = 25'h1 << 20;
    localparam logic [24:0] M_MARIN   = 25'h1 << 19;
    localparam logic [24:0] M_PCIN    = 25'h1 << 18;
    localparam logic [24:0] M_MDRIN   = 25'h1 << 17;
    localparam logic [24:0] M_IRIN    = 25'h1 << 16;
    localparam logic [24:0] M_YIN     = 25'h1 << 15;
    localparam logic [24:0] M_ZIN     = 25'h1 << 14;
    localparam logic [24:0] M_RIN     = 25'h1 << 13;
    localparam logic [24:0] M_LOIN    = 25'h1 << 12;
    localparam logic [24:0] M_HIIN    = 25'h1 << 11;
    localparam logic [24:0] M_INCPC   = 25'h1 << 10;
    localparam logic [24:0] M_READ    = 25'h1 << 9;
    localparam logic [24:0] M_GRA     = 25'h1 << 8;
    localparam logic [24:0] M_GRB     = 25'h1 << 7;
    localparam logic [24:0] M_GRC     = 25'h1 << 6;
    localparam logic [24:0] M_DONE    = 25'h1 << 1;
    localparam logic [24:0] M_ILLEGAL = 25'h1;

    localparam logic [24:0] V_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
    localparam logic [24:0] V_T1 = M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN;
    localparam logic [24:0] V_T2 = M_MDROUT | M_IRIN;
    localparam logic [24:0] V_T5 = M_ZLOWOUT | M_GRA | M_RIN | M_DONE;

    logic [24:0] obs_s;
    assign obs_s = {PCout, Zlowout, Zhighout, MDRout, Rout, MARin, PCin, MDRin, IRin,
                    Yin, Zin, Rin, LOin, HIin, IncPC, Read, Gra, Grb, Grc,
                    AluOp, InstrDone, Illegal};

    logic [24:0] exp_q[$];
    logic [31:0] prog_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [15:0] exp_retired = 16'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    function automatic logic [24:0] alu_v(input logic [3:0] a);
        return {19'd0, a, 2'b00};
    endfunction

    // ALU code table for each supported opcode
    function automatic logic [3:0] exp_alu(input logic [4:0] op);
        case (op)
            5'd3:  return 4'h2;
            5'd4:  return 4'h3;
            5'd5:  return 4'h0;
            5'd6:  return 4'h1;
            5'd7:  return 4'h7;
            5'd8:  return 4'h8;
            5'd9:  return 4'h9;
            5'd10: return 4'hA;
            5'd11: return 4'hB;
            5'd15: return 4'h4;
            5'd16: return 4'h6;
            5'd17: return 4'hC;
            5'd18: return 4'hD;
            default: return 4'h0;
        endcase
    endfunction

    // Queue the full expected strobe sequence of one instruction
    task automatic push_instr(input logic [31:0] ir);
        logic [4:0] op;
        op = ir[31:27];
        prog_q.push_back(ir);
        exp_q.push_back(V_T0);
        exp_q.push_back(V_T1);
        exp_q.push_back(V_T2);
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: begin
                exp_q.push_back(M_GRB | M_ROUT | M_YIN);
                exp_q.push_back(M_GRC | M_ROUT | M_ZIN | alu_v(exp_alu(op)));
                exp_q.push_back(V_T5);
            end
            5'd17, 5'd18: begin
                exp_q.push_back(M_GRB | M_ROUT | M_ZIN | alu_v(exp_alu(op)));
                exp_q.push_back(V_T5);
            end
`ifdef MINISRC_MULDIV_EN
            5'd15, 5'd16: begin
                exp_q.push_back(M_GRA | M_ROUT | M_YIN);
                exp_q.push_back(M_GRB | M_ROUT | M_ZIN | alu_v(exp_alu(op)));
                exp_q.push_back(M_ZLOWOUT | M_LOIN);
                exp_q.push_back(M_ZHIOUT | M_HIIN | M_DONE);
            end
`endif
            default: exp_q.push_back(25'd0);
        endcase
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(25'd0);
    endtask

    task automatic push_err(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(M_ILLEGAL);
    endtask

    // Advance n cycles, checking outputs at each negative edge
    task automatic run_cycles(input int n);
        logic [24:0] e;
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            cyc++;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = 25'd0;
            check_eq($sformatf("strobes@%0d", cyc), {7'd0, obs_s}, {7'd0, e});
            check_eq($sformatf("retired@%0d", cyc), {16'd0, RetiredCnt}, {16'd0, exp_retired});
            if ((e & M_DONE) != 25'd0) exp_retired = exp_retired + 16'd1;
            if (IRin && (prog_q.size() > 0)) IR = prog_q.pop_front();
        end
    endtask

    task automatic do_reset(input int n);
        exp_q.delete();
        prog_q.delete();
        Reset = 1'b1;
        Run = 1'b0;
        exp_retired = 16'd0;
        run_cycles(n);
        Reset = 1'b0;
    endtask

    // Single instruction with Run dropped after T0
    task automatic run_one(input logic [31:0] ir, input int len);
        Run = 1'b1;
        push_instr(ir);
        run_cycles(1);
        Run = 1'b0;
        run_cycles(len - 1 + 2);
    endtask

    initial begin
        Reset = 1'b1;
        Run = 1'b0;
        IR = 32'd0;
        run_cycles(2);
        Reset = 1'b0;

        // ADD r4,r5,r7 with Run falling mid-instruction
        run_one(32'h1A2B8000, 6);

        // Back-to-back AND then OR with Run held high
        Run = 1'b1;
        push_instr(32'h2A2B8000);
        push_idle(int'(GAPS));
        push_instr(32'h322B8000);
        run_cycles(7 + int'(GAPS));
        Run = 1'b0;
        run_cycles(5 + 2);

        // NEG: five cycles, no T4
        run_one(32'h88000000, 5);

        // SUB interrupted by reset in T4
        Run = 1'b1;
        push_instr(32'h20000000);
        run_cycles(5);
        do_reset(2);

        // MUL: legal only with the multiply/divide option
`ifdef MINISRC_MULDIV_EN
        run_one(32'h78000000, 7);
`else
        Run = 1'b1;
        push_instr(32'h78000000);
        push_err(5);
        run_cycles(1);
        Run = 1'b0;
        run_cycles(3 + 5);
`endif
        do_reset(2);

        // Unsupported opcode 31 parks in ERR until reset
        Run = 1'b1;
        push_instr(32'hF8000000);
        push_err(20);
        run_cycles(4 + 20);
        do_reset(2);

        // Recovery after reset: ROL, NOT, SHRA
        run_one(32'h58000000, 6);
        run_one(32'h90000000, 5);
        run_one(32'h40000000, 6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/minisrc_alu_ctrl_seq.md
Name: minisrc_alu_ctrl_seq

Overview:
Hardwired control sequencer for the MiniSRC datapath. It generates the per-step control strobes for the fetch cycle and for register-to-register ALU instructions. It drives the DataPath control inputs, which the benches currently drive by hand, and it reads the IR contents back to choose the ALU operation and the step count. The block sits between the top level and DataPath.

Parameters:
- RUN_IDLE_CYCLES, 0: number of idle cycles inserted between instructions while Run stays high. Range 0..3.

Ports:
- Clock  in  1  system clock. All state changes on the posedge.
- Reset  in  1  synchronous, active-high reset.
- Run  in  1  level. Start, or continue, sequencing instructions.
- IR  in  32  instruction register contents from DataPath.
- PCout, Zlowout, Zhighout, MDRout, Rout  out  1 each  bus drive strobes.
- MARin, PCin, MDRin, IRin, Yin, Zin, Rin, LOin, HIin  out  1 each  register load strobes.
- IncPC, Read  out  1 each  PC increment and memory read.
- Gra, Grb, Grc  out  1 each  register-field select for the select/encode logic.
- AluOp  out  4  ALU operation select.
- InstrDone  out  1  one-cycle pulse in the last step of each instruction.
- Illegal  out  1  sticky flag: the opcode is not supported.
- RetiredCnt  out  16  count of completed instructions.

Behaviour:
- Reset: state=IDLE. Every strobe, AluOp, InstrDone, Illegal and RetiredCnt go to 0. Reset mid-instruction aborts with no further strobes.
- Outputs are decoded combinationally from the state register. T3 and T4 outputs also depend on IR.
- States: IDLE, GAP, T0, T1, T2, T3, T4, T5, T6, ERR.
- IDLE: if Run=1, go to T0 next cycle; otherwise hold.
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, Read, MDRin.
- T2: MDRout, IRin. IR is valid from T3 on.
- T3, opcode = IR[31:27]:
  - Two-operand ops (ADD=3, SUB=4, AND=5, OR=6, SHR=7, SHRA=8, SHL=9, ROR=10, ROL=11): Grb, Rout, Yin.
  - NEG=17, NOT=18: Grb, Rout, AluOp, Zin. Next state is T5 (T4 skipped).
  - Any other opcode: all strobes 0, next state ERR.
- T4: Grc, Rout, AluOp, Zin.
- T5: Zlowout, Gra, Rin, InstrDone.
- End of instruction: RetiredCnt increments on leaving the final step and wraps 0xFFFF->0.
  - Run=1 with RUN_IDLE_CYCLES=0: go directly to T0.
  - Run=1 with RUN_IDLE_CYCLES>0: go to GAP for that many cycles, then T0.
  - Run=0: go to IDLE.
- Run falling mid-instruction has no effect; the instruction completes.
- ERR: Illegal=1, all strobes 0, RetiredCnt unchanged. Exit only via Reset.
- AluOp codes: AND=0, OR=1, ADD=2, SUB=3, MUL=4, DIV=6, SHR=7, SHRA=8, SHL=9, ROR=A, ROL=B, NEG=C, NOT=D. AluOp is 0 outside T3/T4.
- Latency: two-operand ops take 6 cycles (T0–T5). NEG and NOT take 5 cycles.
- Exactly one bus-out strobe may be active per cycle. This is an assertion target.

Optional Feature:
- MINISRC_MULDIV_EN defined: MUL=15 and DIV=16 are legal.
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, AluOp=4 or 6, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin, InstrDone.
  - Total 7 cycles.
- MINISRC_MULDIV_EN undefined: opcodes 15 and 16 go to ERR. The T6 state, LOin, HIin and Zhighout logic are absent; those outputs are tied to 0.

Decomposition:
- minisrc_ctrl_pkg: opcode constants, AluOp constants, state encoding, IR field positions (op 31:27, ra 26:23, rb 22:19, rc 18:15).
- Sub-module minisrc_op_decode: combinational IR-to-{AluOp, is_two_op, is_unary, is_muldiv, illegal}. It is shared with the future branch/memory sequencer.

Test Plan:
- Reset, then Run=1 with IR=0x1A2B8000 (ADD r4,r5,r7) returned in T2: T0..T5 strobes exactly as listed. AluOp=2 only in T4. InstrDone in T5. RetiredCnt=1.
- Back-to-back AND 0x2A2B8000 then OR 0x322B8000 with Run held high, RUN_IDLE_CYCLES=0: the second T0 immediately follows the first T5. AluOp=0 then 1. RetiredCnt=2 after 12 cycles.
- NEG IR=0x88000000: 5 cycles. AluOp=C with Zin in T3. No T4.
- Illegal IR=0xF8000000 (opcode 31): ERR reached after T3. Illegal=1 and all strobes 0 for 20 cycles. Reset clears it.
- Reset asserted in T4 of a SUB: next cycle state=IDLE, all outputs 0, RetiredCnt=0.
- With MINISRC_MULDIV_EN, MUL IR=0x78000000: T5 Zlowout+LOin, T6 Zhighout+HIin, AluOp=4 in T4. Without the macro, the same IR leads to ERR.
